// File: rtl/multiplicador_4bits.sv
// Unsigned 4x4 array multiplier (AND partial products + ripple adder rows), 8-bit registered product.
// Latency: 2 edges from operand capture to c; 3 edges when MULT_PIPE_EN is defined. Throughput 1/cycle.
// No backpressure: free-running, a new operand pair is accepted every cycle.
module multiplicador_4bits (
  input  logic       clk_100M,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] c
);

  // 4-bit ripple adder built from a half adder at bit 0 and full adders above;
  // returns {carry_out, sum}.
  function automatic logic [4:0] ripple4(input logic [3:0] x, input logic [3:0] y);
    logic [4:0] carry;
    logic [3:0] sum;
    carry[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sum[k]       = x[k] ^ y[k] ^ carry[k];
      carry[k + 1] = (x[k] & y[k]) | (carry[k] & (x[k] ^ y[k]));
    end
    return {carry[4], sum};
  endfunction

  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [3:0] pp [0:3];
  logic [4:0] row1;
  logic [4:0] row2;
  logic [4:0] row3;
  logic [7:0] product;

  // Input registers: capture operands every edge, cleared by reset.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      a_q <= 4'd0;
      b_q <= 4'd0;
    end else begin
      a_q <= a;
      b_q <= b;
    end
  end

  // Partial products: row i is the multiplicand gated by multiplier bit i.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pp[i] = a_q & {4{b_q[i]}};
    end
  end

  // Rows 1 and 2: each row adds the next partial product to the upper bits of the
  // running sum; the lowest bit of each row is final and drops out of the array.
  assign row1 = ripple4({1'b0, pp[0][3:1]}, pp[1]);
  assign row2 = ripple4(row1[4:1], pp[2]);

`ifdef MULT_PIPE_EN
  logic [3:0] mid_sum_q;
  logic [2:0] low_bits_q;
  logic [3:0] pp3_q;

  // Mid-array pipeline cut: running sum, settled low bits and the last partial product row.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      mid_sum_q  <= 4'd0;
      low_bits_q <= 3'd0;
      pp3_q      <= 4'd0;
    end else begin
      mid_sum_q  <= row2[4:1];
      low_bits_q <= {row2[0], row1[0], pp[0][0]};
      pp3_q      <= pp[3];
    end
  end

  assign row3    = ripple4(mid_sum_q, pp3_q);
  assign product = {row3, low_bits_q};
`else
  assign row3    = ripple4(row2[4:1], pp[3]);
  assign product = {row3, row2[0], row1[0], pp[0][0]};
`endif

  // Output register: product of the previous stage, cleared by reset.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      c <= 8'd0;
    end else begin
      c <= product;
    end
  end

endmodule

// File: tb/tb_multiplicador_4bits.sv
// Self-checking bench for multiplicador_4bits: directed vectors plus a full 256-pair sweep.
// Expected products are queued by the driver; a monitor pops one entry per edge after the pipeline latency.
// Reset anywhere in the pipeline window forces the expected product to zero.
module tb_multiplicador_4bits;

`ifdef MULT_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       clk_100M;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] c;

  typedef struct {
    bit         chk;
    logic [7:0] exp;
    string      tag;
  } item_t;

  item_t q[$];
  int    checks = 0;
  int    errors = 0;
  int    cycles = 0;

  multiplicador_4bits dut (
    .clk_100M (clk_100M),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .c        (c)
  );

  initial clk_100M = 1'b0;
  always #5 clk_100M = ~clk_100M;

  // Drive one cycle of stimulus and queue the product it should produce.
  task automatic step(input logic r, input logic [3:0] av, input logic [3:0] bv,
                      input logic [7:0] ev, input bit ck, input string tg);
    item_t it;
    @(negedge clk_100M);
    rst = r;
    a   = av;
    b   = bv;
    it.chk = ck;
    it.exp = ev;
    it.tag = tg;
    q.push_back(it);
  endtask

  // Monitor: each edge, compare c against the entry whose operands were sampled LAT-1 edges ago.
  initial begin
    logic [2:0] hist;
    item_t      it;
    logic [7:0] expv;
    hist = 3'b000;
    forever begin
      @(posedge clk_100M);
      #1;
      cycles++;
      if (cycles > 5000) begin
        $display("FAIL watchdog: cycles=%0d limit=5000", cycles);
        $fatal(1, "watchdog expired");
      end
      hist = {hist[1:0], rst};
      if (q.size() >= LAT) begin
        it   = q.pop_front();
        expv = it.exp;
        for (int k = 0; k < LAT; k++) begin
          if (hist[k]) expv = 8'd0;
        end
        if (it.chk) begin
          checks++;
          if (c !== expv) begin
            errors++;
            $display("FAIL %s: c=%0d expected=%0d", it.tag, c, expv);
          end
        end
      end
    end
  end

  // Stimulus: directed vectors with hand-computed products, then the exhaustive sweep.
  initial begin
    logic [3:0] ta [10];
    logic [3:0] tb [10];
    logic [7:0] te [10];
    ta = '{4'd0, 4'd0, 4'd1, 4'd3, 4'd3, 4'd4, 4'd7, 4'd15, 4'd15, 4'd1};
    tb = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd3, 4'd3, 4'd7, 4'd7,  4'd15, 4'd7};
    te = '{8'd0, 8'd0, 8'd1, 8'd3, 8'd9, 8'd12, 8'd49, 8'd105, 8'd225, 8'd7};
    rst = 1'b1;
    a   = 4'd0;
    b   = 4'd0;

    // Reset hold with (15,15) present, then release.
    step(1'b1, 4'd0,  4'd0,  8'd0,   1'b0, "prime");
    step(1'b1, 4'd15, 4'd15, 8'd225, 1'b1, "rst_hold");
    step(1'b1, 4'd15, 4'd15, 8'd225, 1'b1, "rst_hold");
    step(1'b0, 4'd15, 4'd15, 8'd225, 1'b1, "rst_release");
    step(1'b0, 4'd15, 4'd15, 8'd225, 1'b1, "rst_release");

    // Held pairs, two cycles each.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, ta[i], tb[i], te[i], 1'b1, "held_pair");
      step(1'b0, ta[i], tb[i], te[i], 1'b1, "held_pair");
    end

    // Back-to-back pairs.
    step(1'b0, 4'd2,  4'd3, 8'd6,  1'b1, "b2b");
    step(1'b0, 4'd5,  4'd5, 8'd25, 1'b1, "b2b");
    step(1'b0, 4'd15, 4'd1, 8'd15, 1'b1, "b2b");

    // Reset while (15,15) is in flight, then (2,2).
    step(1'b0, 4'd15, 4'd15, 8'd225, 1'b1, "flight_flush");
    step(1'b1, 4'd15, 4'd15, 8'd225, 1'b1, "flight_rst");
    step(1'b0, 4'd2,  4'd2,  8'd4,   1'b1, "after_flush");
    step(1'b0, 4'd2,  4'd2,  8'd4,   1'b1, "after_flush");

    // Exhaustive sweep against the reference product.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        logic [3:0] av;
        logic [3:0] bv;
        logic [7:0] pv;
        av = i[3:0];
        bv = j[3:0];
        pv = 8'(i * j);
        step(1'b0, av, bv, pv, 1'b1, "sweep");
      end
    end

    // Drain the pipeline so every queued check reaches the monitor.
    for (int i = 0; i < LAT; i++) begin
      step(1'b0, 4'd0, 4'd0, 8'd0, 1'b0, "drain");
    end
    @(posedge clk_100M);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
